// File: rtl/sdram_resp_bram.sv
// sdram_resp_bram: block-RAM-backed stand-in for the 16-bit SDRAM controller.
// Answers sdram_rd/sdram_wr requests with a fixed per-type latency, raises
// sdram_busy while working, pulses sdram_ack for one cycle on completion, and
// can periodically stall for refresh so upstream backpressure paths run.
module sdram_resp_bram #(
  parameter int ADDR_W         = 12,
  parameter int RD_LAT         = 3,
  parameter int WR_LAT         = 2,
  parameter int REFRESH_PERIOD = 0,
  parameter int REFRESH_LEN    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [24:0] sdram_addr,
  input  logic        sdram_rd,
  input  logic        sdram_wr,
  input  logic [15:0] sdram_din,
  output logic [15:0] sdram_dout,
  output logic        sdram_ack,
  output logic        sdram_busy,
  output logic        err_drop,
  output logic [15:0] refresh_cnt
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_MAX = (LAT_MAX > REFRESH_LEN) ? LAT_MAX : REFRESH_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PER_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFRESH_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK,
    S_REFRESH
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  acc_load;
  logic              accept;
  logic              collide;
  logic              refresh_done;
  logic              pending;
  logic              wrap;

  // Latched request
  logic              op_wr;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       din_q;

  // RAM read side
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] fetch_idx;
  logic              rd_fetch;

  logic [15:0]       mem [0:(1 << ADDR_W) - 1];

  // Byte-address bit 0 and the bits above the RAM index alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^{sdram_addr[24:ADDR_W+1], sdram_addr[0]};

  assign req_idx  = sdram_addr[ADDR_W:1];
  assign collide  = sdram_rd & sdram_wr;
  assign acc_load = sdram_wr ? WR_LOAD : RD_LOAD;

  // Next-state and countdown logic for the access/refresh sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_next   = state;
    cnt_next     = cnt;
    accept       = 1'b0;
    refresh_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sdram_rd ^ sdram_wr) begin
          // A valid request beats a pending refresh; the refresh follows at ACK exit.
          accept = 1'b1;
          if (acc_load == '0) begin
            state_next = S_ACK;
          end else begin
            state_next = S_ACCESS;
            cnt_next   = acc_load;
          end
        end else if (pending && !collide) begin
          state_next = S_REFRESH;
          cnt_next   = REF_LOAD;
        end
      end
      S_ACCESS: begin
        cnt_next = cnt - CNT_ONE;
        if (cnt_next == '0) state_next = S_ACK;
      end
      S_ACK: begin
        if (pending) begin
          state_next = S_REFRESH;
          cnt_next   = REF_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_REFRESH: begin
        if (cnt == '0) begin
          state_next   = S_IDLE;
          refresh_done = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus registered busy/ack so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sdram_busy <= 1'b0;
      sdram_ack  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sdram_busy <= (state_next != S_IDLE);
      sdram_ack  <= (state_next == S_ACK);
    end
  end

  // Capture op, word index and write data on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr <= 1'b0;
      idx   <= '0;
      din_q <= '0;
    end else if (accept) begin
      op_wr <= sdram_wr;
      idx   <= req_idx;
      din_q <= sdram_din;
    end
  end

  // A read fetches on the edge entering ACK so dout is valid alongside ack.
  // With a one-cycle latency that edge is the accept edge itself, so the
  // index and op come straight from the request.
  assign fetch_idx = accept ? req_idx : idx;
  assign rd_fetch  = (state_next == S_ACK) &&
                     (accept ? sdram_rd : ((state == S_ACCESS) && !op_wr));

  // Read data register; holds until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_dout <= '0;
    end else if (rd_fetch) begin
      sdram_dout <= mem[fetch_idx];
    end
  end

  // Write port: commit during the ACK cycle, so a reset before ACK drops the write.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; clearing it would defeat block-RAM
    // mapping, and its contents are meant to survive rst_n.
    if (state == S_ACK && op_wr) begin
      mem[idx] <= din_q;
    end
  end

  // Sticky error: strobe while busy, or rd and wr together while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop <= 1'b0;
    end else if (((state != S_IDLE) && (sdram_rd || sdram_wr)) ||
                 ((state == S_IDLE) && collide)) begin
      err_drop <= 1'b1;
    end
  end

  // Refresh timer: free-running 0..REFRESH_PERIOD-1, wrap flags a refresh.
  if (REFRESH_PERIOD > 0) begin : g_refresh
    logic [PER_W-1:0] per_cnt;

    assign wrap = (per_cnt == PER_W'(REFRESH_PERIOD - 1));

    // Period counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= wrap ? '0 : per_cnt + PER_W'(1);
      end
    end
  end else begin : g_no_refresh
    assign wrap = 1'b0;
  end

  // Pending flag: a wrap while already pending is simply lost, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b1;
    end else if (refresh_done) begin
      pending <= 1'b0;
    end
  end

  // Completed-refresh counter, wrapping at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else if (refresh_done) begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_resp_bram.sv
// Self-checking bench for sdram_resp_bram. dut_a runs without refresh and gets
// directed plus randomized traffic checked against a word-indexed memory model
// and the per-type latency; dut_r has refresh enabled for stall-timing checks.
module tb_sdram_resp_bram;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;
  localparam int PERIOD = 20;
  localparam int RLEN   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [24:0] a_addr, r_addr;
  logic        a_rd, a_wr, r_rd, r_wr;
  logic [15:0] a_din, r_din;
  logic [15:0] a_dout, r_dout;
  logic        a_ack, a_busy, a_err, r_ack, r_busy, r_err;
  logic [15:0] a_rcnt, r_rcnt;

  sdram_resp_bram #(
    .ADDR_W(12), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .REFRESH_PERIOD(0), .REFRESH_LEN(RLEN)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sdram_addr(a_addr), .sdram_rd(a_rd), .sdram_wr(a_wr),
    .sdram_din(a_din), .sdram_dout(a_dout), .sdram_ack(a_ack), .sdram_busy(a_busy),
    .err_drop(a_err), .refresh_cnt(a_rcnt)
  );

  sdram_resp_bram #(
    .ADDR_W(12), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .REFRESH_PERIOD(PERIOD), .REFRESH_LEN(RLEN)
  ) dut_r (
    .clk(clk), .rst_n(rst_n), .sdram_addr(r_addr), .sdram_rd(r_rd), .sdram_wr(r_wr),
    .sdram_din(r_din), .sdram_dout(r_dout), .sdram_ack(r_ack), .sdram_busy(r_busy),
    .err_drop(r_err), .refresh_cnt(r_rcnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [int];
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [24:0] a);
    return int'((a >> 1) % 4096);
  endfunction

  // Reset both instances; releases on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    a_rd = 1'b0; a_wr = 1'b0; r_rd = 1'b0; r_wr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = 16'h0;
  endtask

  // One access on dut_a; entered and left just after a falling edge.
  task automatic a_access(input bit is_wr, input logic [24:0] addr, input logic [15:0] data);
    int lat;
    bit got;
    check("a_idle_before", a_busy, 1'b0);
    a_addr = addr; a_din = data; a_wr = is_wr; a_rd = !is_wr;
    @(posedge clk);
    #1;
    a_rd = 1'b0; a_wr = 1'b0;
    a_din = 16'($urandom); a_addr = 25'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (a_ack) got = 1'b1;
      else check("a_busy_wait", a_busy, 1'b1);
    end
    check("a_ack_seen", got, 1'b1);
    check("a_latency", lat, is_wr ? WR_LAT : RD_LAT);
    check("a_busy_in_ack", a_busy, 1'b1);
    if (is_wr) begin
      model[widx(addr)] = data;
      check("a_dout_hold", a_dout, last_rd);
    end else begin
      check("a_rd_data", a_dout, model[widx(addr)]);
      last_rd = model[widx(addr)];
    end
    @(negedge clk);
    check("a_ack_one_cycle", a_ack, 1'b0);
    check("a_busy_fall", a_busy, 1'b0);
  endtask

  // Expected refresh busy in the cycle after edge n of an idle run from reset.
  function automatic bit exp_ref_busy(input int n);
    return (n - 1 >= PERIOD) && (((n - 1) % PERIOD) < RLEN);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] word64;
    logic [24:0] addr;
    int acks, lat, run, busy_seen, ack_seen, mism, busy_tot, windows;
    bit  prev, got;

    a_addr = '0; a_din = '0; r_addr = '0; r_din = '0;
    do_reset();

    // Reset state
    check("rst_dout", a_dout, 16'h0);
    check("rst_ack", a_ack, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_rcnt", a_rcnt, 16'h0);

    // Write/readback
    a_access(1'b1, 25'h000010, 16'hBEEF);
    a_access(1'b0, 25'h000010, 16'h0);
    check("readback_beef", a_dout, 16'hBEEF);

    // Aliasing and bit 0
    a_access(1'b1, 25'h000003, 16'h1234);
    a_access(1'b0, 25'h000002, 16'h0);
    check("alias_bit0", a_dout, 16'h1234);
    a_access(1'b0, 25'h002002, 16'h0);
    check("alias_high", a_dout, 16'h1234);

    // Shim-style 64-bit word at core address 5 -> bytes 0x28..0x2F
    a_access(1'b1, 25'h000028, 16'h0123);
    a_access(1'b1, 25'h00002A, 16'h4567);
    a_access(1'b1, 25'h00002C, 16'h89AB);
    a_access(1'b1, 25'h00002E, 16'hCDEF);
    word64 = '0;
    for (int i = 0; i < 4; i++) begin
      a_access(1'b0, 25'h000028 + 25'(2 * i), 16'h0);
      word64 = {word64[47:0], a_dout};
    end
    check("shim_word64", word64, 64'h0123456789ABCDEF);

    // Randomized traffic over 16 words with random alias bits and gaps
    for (int i = 0; i < 16; i++) a_access(1'b1, 25'(2 * i), 16'($urandom));
    for (int i = 0; i < 150; i++) begin
      addr = 25'($urandom);
      addr[12:1] = 12'($urandom_range(0, 15));
      a_access(1'($urandom), addr, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("no_err_after_traffic", a_err, 1'b0);

    // Busy drop: rd held through cycle E0+1 of an in-flight read
    a_addr = 25'h000010; a_rd = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 a_rd = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ack) begin
        acks++;
        check("drop_rd_data", a_dout, model[widx(25'h000010)]);
      end
    end
    check("drop_single_ack", acks, 1);
    check("drop_err", a_err, 1'b1);

    // Collision in IDLE
    do_reset();
    check("coll_err_clear", a_err, 1'b0);
    a_addr = 25'h000010; a_din = ~model[widx(25'h000010)];
    a_rd = 1'b1; a_wr = 1'b1;
    @(posedge clk);
    #1 a_rd = 1'b0; a_wr = 1'b0;
    busy_seen = 0; ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_busy) busy_seen++;
      if (a_ack) ack_seen++;
    end
    check("coll_no_busy", busy_seen, 0);
    check("coll_no_ack", ack_seen, 0);
    check("coll_err", a_err, 1'b1);
    a_access(1'b0, 25'h000010, 16'h0);

    // Reset during ACCESS of a write
    a_access(1'b1, 25'h000040, 16'h5555);
    a_access(1'b0, 25'h000040, 16'h0);
    a_addr = 25'h000040; a_din = 16'hAAAA; a_wr = 1'b1;
    @(posedge clk);
    #1 a_wr = 1'b0;
    #1;
    check("midwr_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midwr_dout0", a_dout, 16'h0);
    check("midwr_ack0", a_ack, 1'b0);
    check("midwr_busy0", a_busy, 1'b0);
    check("midwr_err0", a_err, 1'b0);
    check("midwr_rcnt0", r_rcnt, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 16'h0;
    a_access(1'b0, 25'h000040, 16'h0);
    check("midwr_old_data", a_dout, 16'h5555);

    // Request coincident with a pending refresh: access first, then the stall
    do_reset();
    repeat (PERIOD) @(posedge clk);
    @(negedge clk);
    check("coinc_idle", r_busy, 1'b0);
    check("coinc_rcnt0", r_rcnt, 16'h0);
    r_addr = 25'h000030; r_din = 16'h3C3C; r_wr = 1'b1;
    @(posedge clk);
    #1 r_wr = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (r_ack) got = 1'b1;
    end
    check("coinc_ack_seen", got, 1'b1);
    check("coinc_latency", lat, WR_LAT);
    run = 0; ack_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_ack) ack_seen++;
      if (!r_busy) break;
      run++;
    end
    check("coinc_refresh_len", run, RLEN);
    check("coinc_no_extra_ack", ack_seen, 0);
    check("coinc_rcnt", r_rcnt, 16'h1);

    // Idle run with refresh only
    do_reset();
    mism = 0; busy_tot = 0; windows = 0; prev = 1'b0;
    for (int n = 1; n <= 105; n++) begin
      @(negedge clk);
      if (r_busy !== exp_ref_busy(n)) mism++;
      if (r_busy) busy_tot++;
      if (r_busy && !prev) windows++;
      prev = r_busy;
    end
    check("idle_busy_pattern", mism, 0);
    check("idle_busy_total", busy_tot, 5 * RLEN);
    check("idle_windows", windows, 5);
    check("idle_rcnt", r_rcnt, 16'd5);
    check("idle_no_ack", r_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
